// File: rtl/data_memory.sv
// ============================================================================
// data_memory
// ----------------------------------------------------------------------------
// Single-port 2**ADDR_WIDTH x DATA_WIDTH data memory for the SIC-4 datapath.
// Reads are asynchronous, so load instructions see their data in the same
// cycle as the address. Writes are synchronous. One address bus serves both.
// A synchronous reset clears every word in a single edge.
//
// Parameters:
//   DATA_WIDTH   - word width (default 8)
//   ADDR_WIDTH   - address width, depth = 2**ADDR_WIDTH (default 8 -> 256)
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   reset        - synchronous active-high, clears the whole array
//   addr         - word address shared by read and write
//   write_data   - word stored when write_enable is high
//   write_enable - active-high write strobe, sampled on rising clk
//   data         - combinational read data, mem[addr]
// ============================================================================
module data_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a simultaneous write so the array comes out of a reset
    // edge fully cleared; any write presented on that edge is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable) begin
            mem[addr] <= write_data;
        end
    end

    // No bypass: a word being written shows its old value until the edge.
    assign data = mem[addr];

endmodule

// File: tb/tb_data_memory.sv
// ============================================================================
// tb_data_memory
// ----------------------------------------------------------------------------
// Self-checking bench for data_memory. A reference array tracks the expected
// memory contents; each read pushes its expected word onto a queue, which is
// popped and compared once the DUT output has settled.
// ============================================================================
module tb_data_memory;

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] write_data;
    logic       write_enable;
    logic [7:0] data;

    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] expv;
    int         total_checks;
    int         passed_checks;

    data_memory #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .data         (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write on the next rising edge and mirrors it in the model.
    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        model_mem[a] = d;
    endtask

    // Holds reset for one edge; the model is cleared to match.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    endtask

    task automatic test_reset();
        write_word(8'h10, 8'hAA);
        pulse_reset();
        foreach (model_mem[i]) begin
            if (i == 'h10 || i == 'h00 || i == 'hFF) begin
                exp_q.push_back(model_mem[i]);
                addr = 8'(i);
                #1;
                expv = exp_q.pop_front();
                total_checks++;
                if (data !== expv)
                    $display("[TB] FAIL reset_clear addr=%02h got=%02h want=%02h", addr, data, expv);
                else
                    passed_checks++;
            end
        end
    endtask

    task automatic test_write_read();
        write_word(8'h55, 8'hDE);
        // Disabled write with different data must leave the word alone.
        @(negedge clk);
        addr         = 8'h55;
        write_data   = 8'h25;
        write_enable = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(8'hDE);
        expv = exp_q.pop_front();
        total_checks++;
        if (data !== expv)
            $display("[TB] FAIL write_read got=%02h want=%02h", data, expv);
        else
            passed_checks++;
    endtask

    task automatic test_untouched();
        logic [7:0] seq_addr [3];
        seq_addr = '{8'h02, 8'h02, 8'h55};
        for (int k = 0; k < 3; k++) begin
            if (k == 1) write_word(8'h02, 8'h1F);
            exp_q.push_back(model_mem[seq_addr[k]]);
            addr = seq_addr[k];
            #1;
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL untouched_step%0d addr=%02h got=%02h want=%02h", k, addr, data, expv);
            else
                passed_checks++;
        end
    endtask

    task automatic test_comb_read();
        write_word(8'h00, 8'h11);
        write_word(8'hFF, 8'h22);
        // Toggle the address several times inside one clock low phase.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            addr = (k % 2 == 0) ? 8'h00 : 8'hFF;
            exp_q.push_back((k % 2 == 0) ? 8'h11 : 8'h22);
            #1;
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL comb_read addr=%02h got=%02h want=%02h", addr, data, expv);
            else
                passed_checks++;
        end
    endtask

    task automatic test_reset_collision();
        @(negedge clk);
        reset        = 1'b1;
        write_enable = 1'b1;
        addr         = 8'h30;
        write_data   = 8'h77;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        exp_q.push_back(8'h00);
        expv = exp_q.pop_front();
        total_checks++;
        if (data !== expv)
            $display("[TB] FAIL reset_priority got=%02h want=%02h", data, expv);
        else
            passed_checks++;
        reset = 1'b0;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        model_mem[8'h30] = 8'h77;
        exp_q.push_back(8'h77);
        expv = exp_q.pop_front();
        total_checks++;
        if (data !== expv)
            $display("[TB] FAIL write_after_reset got=%02h want=%02h", data, expv);
        else
            passed_checks++;
        // The words written before the collision were cleared as well.
        exp_q.push_back(8'h00);
        addr = 8'h55;
        #1;
        expv = exp_q.pop_front();
        total_checks++;
        if (data !== expv)
            $display("[TB] FAIL reset_cleared_55 got=%02h want=%02h", data, expv);
        else
            passed_checks++;
    endtask

    task automatic test_boundary();
        logic [7:0] probe [4];
        logic [7:0] want  [4];
        probe = '{8'h00, 8'hFF, 8'h01, 8'hFE};
        want  = '{8'h01, 8'h80, 8'h00, 8'h00};
        write_word(8'h00, 8'h01);
        write_word(8'hFF, 8'h80);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(want[k]);
            addr = probe[k];
            #1;
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL boundary addr=%02h got=%02h want=%02h", addr, data, expv);
            else
                passed_checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] d;
        // Write on consecutive edges; before each edge the old word must show.
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            a = 8'(8'h40 + k * 3);
            d = 8'($urandom_range(1, 255));
            addr         = a;
            write_data   = d;
            write_enable = 1'b1;
            exp_q.push_back(model_mem[a]);
            #1;
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL rdw_old addr=%02h got=%02h want=%02h", a, data, expv);
            else
                passed_checks++;
            @(posedge clk);
            model_mem[a] = d;
            #1;
            exp_q.push_back(d);
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL rdw_new addr=%02h got=%02h want=%02h", a, data, expv);
            else
                passed_checks++;
            @(negedge clk);
        end
        write_enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = 8'(8'h40 + k * 3);
            exp_q.push_back(model_mem[a]);
            addr = a;
            #1;
            expv = exp_q.pop_front();
            total_checks++;
            if (data !== expv)
                $display("[TB] FAIL b2b_readback addr=%02h got=%02h want=%02h", a, data, expv);
            else
                passed_checks++;
        end
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset         = 1'b0;
        addr          = 8'h00;
        write_data    = 8'h00;
        write_enable  = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        test_reset();
        test_write_read();
        test_untouched();
        test_comb_read();
        test_reset_collision();
        test_boundary();
        test_back_to_back();

        if (exp_q.size() != 0) begin
            total_checks++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
